// File: rtl/rect_from_polar_if.sv
// rect_from_polar_if: request/result bundle for the polar-to-rectangular converter
interface rect_from_polar_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [31:0] mag;
  logic [31:0] angle;
  logic [31:0] re;
  logic [31:0] im;
  modport master (output start, mag, angle, input busy, done, re, im);
  modport slave (input start, mag, angle, output busy, done, re, im);
endinterface

// File: rtl/rect_from_polar.sv
// rect_from_polar: float32 mag/angle to re/im via one shared multiplier and adder
module rect_from_polar (
  input logic             clk,
  input logic             rst,
  rect_from_polar_if.slave bus
);
  localparam logic [31:0] c_pi = 32'h40490FDB;
  localparam logic [31:0] c_half_pi = 32'h3FC90FDB;
  localparam logic [31:0] c_one = 32'h3F800000;
  localparam logic [31:0] sin_c [4] = '{32'h3C638E39, 32'h3CC30C31, 32'h3D4CCCCD, 32'h3E2AAAAB};
  localparam logic [31:0] cos_c [4] = '{32'h3C924925, 32'h3D088889, 32'h3DAAAAAB, 32'h3F000000};
  typedef enum logic [3:0] {IDLE, REDUCE, SQUARE, MA, MB, AD, SIN_FIN, SCALE_RE, SCALE_IM, DONE} state_t;
  // Denormal operands are treated as zero; results round to nearest even.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  e;
    logic [22:0] f;
    logic        g, st, s;
    logic [23:0] fr;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {s, 31'd0};
    m = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
    {f, g, st} = m[47] ? {m[46:24], m[23], |m[22:0]} : {m[45:23], m[22], |m[21:0]};
    e = m[47] ? e + 10'd1 : e;
    fr = {1'b0, f} + {23'd0, g & (st | f[0])};
    e = fr[23] ? e + 10'd1 : e;
    if (e[9] || e == 10'd0) return {s, 31'd0};
    if (e >= 10'd255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], fr[22:0]};
  endfunction
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] hi, lo;
    logic [27:0] mh, ml, sum;
    logic [7:0]  d;
    logic [9:0]  e;
    logic [23:0] fr;
    if (a[30:23] == 8'd0) return (b[30:23] == 8'd0) ? {a[31] & b[31], 31'd0} : b;
    if (b[30:23] == 8'd0) return a;
    hi = (a[30:0] >= b[30:0]) ? a : b;
    lo = (a[30:0] >= b[30:0]) ? b : a;
    d = hi[30:23] - lo[30:23];
    mh = {2'b01, hi[22:0], 3'b000};
    ml = {2'b01, lo[22:0], 3'b000};
    ml = (d > 8'd26) ? 28'd1 : ((ml >> d) | {27'd0, |(ml & ~(28'hFFFFFFF << d))});
    sum = (hi[31] == lo[31]) ? mh + ml : mh - ml;
    if (sum == 28'd0) return 32'd0;
    e = {2'b00, hi[30:23]};
    if (sum[27]) begin
      sum = {1'b0, sum[27:2], sum[1] | sum[0]};
      e = e + 10'd1;
    end
    for (int i = 0; i < 26; i++)
      if (!sum[26]) begin
        sum = sum << 1;
        e = e - 10'd1;
      end
    fr = {1'b0, sum[25:3]} + {23'd0, sum[2] & (sum[1] | sum[0] | sum[3])};
    e = fr[23] ? e + 10'd1 : e;
    if (e[9] || e == 10'd0) return {hi[31], 31'd0};
    if (e >= 10'd255) return {hi[31], 8'hFF, 23'd0};
    return {hi[31], e[7:0], fr[22:0]};
  endfunction
  state_t      state_q, state_d;
  logic [31:0] mag_q, mag_d, ang_q, ang_d, x_q, x_d, x2_q, x2_d, acc_q, acc_d, p_q, p_d;
  logic [31:0] s_q, s_d, re_t_q, re_t_d, re_q, re_d, im_q, im_d;
  logic [1:0]  k_q, k_d;
  logic        cos_q, cos_d, flip_q, flip_d;
  logic [31:0] coef, mul_a, mul_b, mul_r, add_a, add_b, add_r;
  always_comb begin
    coef = cos_q ? cos_c[k_q] : sin_c[k_q];
    mul_a = (state_q == SQUARE || state_q == SIN_FIN) ? x_q : state_q == MA ? x2_q : state_q == MB ? p_q : mag_q;
    mul_b = state_q == SQUARE ? x_q : state_q == MB ? coef : state_q == SCALE_IM ? s_q : acc_q;
    add_a = state_q == REDUCE ? ang_q : c_one;
    add_b = state_q == REDUCE ? {~ang_q[31], c_pi[30:0]} : {~p_q[31], p_q[30:0]};
    mul_r = fmul(mul_a, mul_b);
    add_r = fadd(add_a, add_b);
  end
  always_comb begin
    state_d = state_q;
    mag_d = mag_q;
    ang_d = ang_q;
    x_d = x_q;
    x2_d = x2_q;
    acc_d = acc_q;
    p_d = p_q;
    s_d = s_q;
    re_t_d = re_t_q;
    re_d = re_q;
    im_d = im_q;
    k_d = k_q;
    cos_d = cos_q;
    flip_d = flip_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = REDUCE;
        mag_d = bus.mag;
        ang_d = bus.angle;
      end
      REDUCE: begin
        flip_d = ang_q[30:0] > c_half_pi[30:0];
        x_d = flip_d ? add_r : ang_q;
        state_d = SQUARE;
      end
      SQUARE: begin
        x2_d = mul_r;
        acc_d = c_one;
        k_d = 2'd0;
        cos_d = 1'b0;
        state_d = MA;
      end
      MA: begin
        p_d = mul_r;
        state_d = MB;
      end
      MB: begin
        p_d = mul_r;
        state_d = AD;
      end
      AD: begin
        acc_d = add_r;
        k_d = k_q + 2'd1;
        state_d = k_q != 2'd3 ? MA : cos_q ? SCALE_RE : SIN_FIN;
      end
      // k has wrapped to 0, so the cosine pass restarts the same triple
      SIN_FIN: begin
        s_d = mul_r;
        acc_d = c_one;
        cos_d = 1'b1;
        state_d = MA;
      end
      SCALE_RE: begin
        re_t_d = {mul_r[31] ^ flip_q, mul_r[30:0]};
        state_d = SCALE_IM;
      end
      SCALE_IM: begin
        re_d = re_t_q;
        im_d = {mul_r[31] ^ flip_q, mul_r[30:0]};
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mag_q <= '0;
      ang_q <= '0;
      x_q <= '0;
      x2_q <= '0;
      acc_q <= '0;
      p_q <= '0;
      s_q <= '0;
      re_t_q <= '0;
      re_q <= '0;
      im_q <= '0;
      k_q <= '0;
      cos_q <= 1'b0;
      flip_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q <= mag_d;
      ang_q <= ang_d;
      x_q <= x_d;
      x2_q <= x2_d;
      acc_q <= acc_d;
      p_q <= p_d;
      s_q <= s_d;
      re_t_q <= re_t_d;
      re_q <= re_d;
      im_q <= im_d;
      k_q <= k_d;
      cos_q <= cos_d;
      flip_q <= flip_d;
    end
  end
  assign bus.busy = state_q != IDLE && state_q != DONE;
  assign bus.done = state_q == DONE;
  assign bus.re = re_q;
  assign bus.im = im_q;
endmodule

// File: tb/tb_rect_from_polar.sv
// tb_rect_from_polar: directed vectors with hand-computed expectations
module tb_rect_from_polar;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vecs = 0;
  int errs = 0;
  int lat, d1, d2, both, seen;
  rect_from_polar_if bus();
  rect_from_polar dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic real f2r(input logic [31:0] b);
    real m;
    int e;
    if (b[30:23] == 8'd0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    e = int'(b[30:23]) - 127;
    for (int i = 0; i < e; i++) m = m * 2.0;
    for (int i = 0; i > e; i--) m = m / 2.0;
    return b[31] ? -m : m;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_near(input string tag, input logic [31:0] obs, input real exp, input real tol);
    real v;
    v = f2r(obs);
    vecs++;
    assert (v - exp <= tol && exp - v <= tol) else begin
      errs++;
      $error("FAIL %s: observed %h (%f) expected %f within %g", tag, obs, v, exp, tol);
    end
  endtask
  // Returns the index of the cycle after the accept edge in which done is high, or -1.
  task automatic run(input logic [31:0] m, input logic [31:0] a, output int n);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag = m;
    bus.angle = a;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mag = 32'hDEADBEEF;
    bus.angle = 32'hDEADBEEF;
    chk("busy_after_accept", {31'd0, bus.busy}, 32'd1);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      if (bus.done) begin
        n = i;
        break;
      end
      @(negedge clk);
    end
    chk("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
  endtask
  initial begin
    bus.start = 1'b0;
    bus.mag = '0;
    bus.angle = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'd0, bus.busy}, 32'd0);
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    chk("reset_re", bus.re, 32'h00000000);
    chk("reset_im", bus.im, 32'h00000000);
    rst = 1'b0;
    run(32'h3F800000, 32'h00000000, lat);
    chk("zero_latency", 32'(lat), 32'd30);
    chk("zero_re", bus.re, 32'h3F800000);
    chk("zero_im", bus.im, 32'h00000000);
    @(negedge clk);
    chk("done_one_cycle", {31'd0, bus.done}, 32'd0);
    run(32'h40000000, 32'h40490FDB, lat);
    chk("flip_latency", 32'(lat), 32'd30);
    chk("flip_re", bus.re, 32'hC0000000);
    chk("flip_im", bus.im, 32'h80000000);
    run(32'h3FB504F3, 32'h3F490FDB, lat);
    chk_near("q1_re", bus.re, 1.0, 7e-5);
    chk_near("q1_im", bus.im, 1.0, 7e-5);
    run(32'h3F800000, 32'hBFC90FDB, lat);
    chk_near("neg_re", bus.re, 0.0, 5e-5);
    chk_near("neg_im", bus.im, -1.0, 5e-5);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag = 32'h3F800000;
    bus.angle = 32'h00000000;
    d1 = -1;
    d2 = -1;
    both = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (bus.done && bus.busy) both++;
      if (bus.done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) begin
          d2 = i;
          bus.start = 1'b0;
        end
      end
    end
    bus.start = 1'b0;
    chk("held_first_done", 32'(d1), 32'd30);
    chk("held_period", 32'(d2 - d1), 32'd31);
    chk("done_busy_overlap", 32'(both), 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.mag = 32'h3FB504F3;
    bus.angle = 32'h3F490FDB;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(seen), 32'd0);
    chk("abort_busy", {31'd0, bus.busy}, 32'd0);
    chk("abort_re", bus.re, 32'h00000000);
    chk("abort_im", bus.im, 32'h00000000);
    run(32'h3F800000, 32'h00000000, lat);
    chk("post_abort_latency", 32'(lat), 32'd30);
    chk("post_abort_re", bus.re, 32'h3F800000);
    chk("post_abort_im", bus.im, 32'h00000000);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
